fp16_adder: RTL and testbench
=============================

// Module: fp16_adder
// PURPOSE
//  IEEE-754 binary16 (half-precision) adder for the 8-point FFT butterfly datapath.
//  Adds two fp16 operands (1 sign, 5 exp bias 15, 10 frac) and registers the fp16 sum plus status flags.
//  Supports subnormals, infinities and NaN. One result per clock, fully pipelined at 1 cycle latency.
// PARAMETERS
//  none. All widths are fixed by the fp16 format; constants live in fp16_pkg.
// PORTS
//  Clock and reset: one clock; reset is synchronous and active-high (ports clk, rst).
//  clk            in   1   rising-edge clock
//  rst            in   1   synchronous active-high reset
//  num1           in   16  operand A {sign,exp[4:0],frac[9:0]}
//  num2           in   16  operand B, same format
//  result         out  16  registered sum A+B
//  overflow       out  1   finite operands, rounded magnitude exceeds 65504; result=+/-inf
//  zero           out  1   result is +/-0
//  nan            out  1   result is NaN
//  precisionLost  out  1   nonzero bits discarded by alignment/rounding (inexact)
// BEHAVIOUR
//  - Reset: result=16'h0000, all flags 0, applied on the clk edge while rst=1.
//  - Latency 1: inputs sampled at edge N appear on result/flags after edge N; new operands accepted every cycle.
//  - Unpack: exp==0 gives hidden bit 0 and effective exp 1 (subnormal); otherwise hidden bit 1.
//  - Align: swap so |A|>=|B| (compare {exp,frac}). Shift smaller significand right by the exp difference.
//    Keep guard, round and sticky bits. A difference >=14 collapses B entirely into sticky.
//  - Same sign: add significands, which may carry into bit 11 (shift right 1, exp+1).
//    Different sign: subtract smaller from larger; result sign = sign of the larger magnitude.
//  - Normalize: left-shift by leading-zero count, limited so exp does not go below 1.
//    A result below 1.0*2^-14 is encoded subnormal (exp field 0).
//  - Rounding: truncate (toward zero) by default. precisionLost = guard|round|sticky before rounding.
//  - Exact cancellation (equal magnitude, opposite sign): result=16'h0000, zero=1.
//    Zero inputs: 0+x=x; +0 + -0 = +0.
//  - Overflow: exp after normalize/round >=31 gives result={sign,5'h1F,10'h0}, overflow=1.
//  - Special cases (have priority):
//    - Either input NaN (exp=31, frac!=0): result=16'h7E00, nan=1.
//    - +inf + -inf: result=16'h7E00, nan=1.
//    - inf + finite: that inf, overflow=0.
//    - inf + same-sign inf: that inf.
//  - Flags are mutually consistent: nan excludes zero/overflow; precisionLost=0 for special cases.
// CONFIGURATION
//  FP16_ADD_RNE_EN defined: round-to-nearest-even using guard/round/sticky.
//    A mantissa carry from rounding increments exp and may trigger overflow.
//    precisionLost keeps the same definition.
//  Undefined (default): truncation as above. Results for exact sums are identical in both builds.
// STRUCTURE
//  - Package fp16_pkg:
//    - localparams EXP_W=5, FRAC_W=10, BIAS=15
//    - QNAN=16'h7E00, POS_INF=16'h7C00, NEG_INF=16'hFC00
//    - typedef struct fp16_t {sign,exp,frac}.
//  - Sub-module fp16_lzc: combinational 14-bit leading-zero counter used by the normalizer.
//  - Top: combinational unpack/align/add/normalize/round, then a single output register stage.
// TESTING
//  - B9A8 (-0.707) + C03E (-2.121) -> C1A8 (-2.828); all flags 0 one cycle later.
//  - C03E (-2.121) + 39A8 (+0.707) -> BDA8 (-1.414): opposite signs with renormalize by 1.
//  - C200 (-3) + C1A8 (-2.828) -> C5D4 (-5.828), exp carry; BC00 (-1) + BDA8 -> C0D4 (-2.414).
//  - Subnormal 00B8 + 0080 -> 0138.
//    B200 + 3200 -> 0000, zero=1.
//    7BFF + 7BFF -> 7C00, overflow=1.
//    7C01 + 3C00 -> 7E00, nan=1.
//    7C00 + FC00 -> 7E00, nan=1.
//  - 5400 + 0001 -> 5400, precisionLost=1.
//    Back-to-back operands every cycle give one result per cycle in order.
//    rst asserted mid-stream -> result=0000, flags 0 on the next edge.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared fp16 format constants and the packed operand view used by the adder.
package fp16_pkg;
  localparam int EXP_W  = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS   = 15;

  // Widened exponent value at which a finite result becomes infinity.
  localparam logic [5:0] EXP_MAX = 6'(2 * BIAS + 1);

  localparam logic [15:0] QNAN    = 16'h7E00;
  localparam logic [15:0] POS_INF = 16'h7C00;
  localparam logic [15:0] NEG_INF = 16'hFC00;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;
endpackage

// File: rtl/fp16_lzc.sv
// Combinational 14-bit leading-zero counter; an all-zero input reports 14.
module fp16_lzc (
  input  logic [13:0] data_i,
  output logic [3:0]  count_o
);
  always_comb begin
    count_o = 4'd14;
    // Ascending scan so the highest set bit is the last one to write.
    for (int i = 0; i < 14; i++) begin
      if (data_i[i]) count_o = 4'(13 - i);
    end
  end
endmodule

// File: rtl/fp16_adder.sv
// Binary16 adder with one output register stage. Define FP16_ADD_RNE_EN for
// round-to-nearest-even; the default build truncates toward zero.
module fp16_adder
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] num1,
  input  logic [15:0] num2,
  output logic [15:0] result,
  output logic        overflow,
  output logic        zero,
  output logic        nan,
  output logic        precisionLost
);
  fp16_t             a, b, big;
  logic              swap, same_sign;
  logic [EXP_W-1:0]  small_exp;
  logic [FRAC_W-1:0] small_frac;
  logic [5:0]        e_big, e_small, e_diff, e_norm, e_field, shamt;
  logic [10:0]       sig_big, sig_small;
  logic [24:0]       shifted;
  logic [13:0]       a_al, b_al, norm;
  logic [14:0]       sum;
  logic [3:0]        lz;
  logic [15:0]       mag;
  logic              grs, round_up, fin_ovf;
  logic              a_nan, b_nan, a_inf, b_inf;
  logic [15:0]       result_d, result_q;
  logic              overflow_d, overflow_q, zero_d, zero_q;
  logic              nan_d, nan_q, lost_d, lost_q;

  assign a = fp16_t'(num1);
  assign b = fp16_t'(num2);

  // Raw {exp,frac} ordering matches magnitude ordering, subnormals included.
  assign swap       = {b.exp, b.frac} > {a.exp, a.frac};
  assign big        = swap ? b : a;
  assign small_exp  = swap ? a.exp : b.exp;
  assign small_frac = swap ? a.frac : b.frac;
  assign same_sign  = (a.sign == b.sign);

  assign e_big     = (big.exp == '0) ? 6'd1 : {1'b0, big.exp};
  assign e_small   = (small_exp == '0) ? 6'd1 : {1'b0, small_exp};
  assign sig_big   = {big.exp != '0, big.frac};
  assign sig_small = {small_exp != '0, small_frac};
  assign e_diff    = e_big - e_small;

  // Aligned layout: [13:3] significand, [2] guard, [1] round, [0] sticky.
  assign shifted = {sig_small, 14'b0} >> e_diff;
  assign a_al    = {sig_big, 3'b000};
  assign b_al    = (e_diff >= 6'd14) ? {13'b0, |sig_small}
                                     : {shifted[24:12], |shifted[11:0]};
  assign sum     = same_sign ? ({1'b0, a_al} + {1'b0, b_al})
                             : ({1'b0, a_al} - {1'b0, b_al});

  fp16_lzc u_lzc (
    .data_i  (sum[13:0]),
    .count_o (lz)
  );

  always_comb begin
    shamt  = 6'd0;
    norm   = sum[13:0];
    e_norm = e_big;
    if (sum[14]) begin
      norm   = {sum[14:2], |sum[1:0]};
      e_norm = e_big + 6'd1;
    end else begin
      // Stop at exponent 1 so tiny results land in subnormal encoding.
      shamt  = ({2'b00, lz} < (e_big - 6'd1)) ? {2'b00, lz} : (e_big - 6'd1);
      norm   = sum[13:0] << shamt;
      e_norm = e_big - shamt;
    end
  end

  assign grs = |norm[2:0];
`ifdef FP16_ADD_RNE_EN
  assign round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
`else
  assign round_up = 1'b0;
`endif
  // A rounding carry out of the fraction ripples straight into the exponent.
  assign e_field = norm[13] ? e_norm : 6'd0;
  assign mag     = {e_field, norm[12:3]} + {15'b0, round_up};
  assign fin_ovf = (mag[15:10] >= EXP_MAX);

  assign a_nan = (a.exp == 5'h1F) && (a.frac != '0);
  assign b_nan = (b.exp == 5'h1F) && (b.frac != '0);
  assign a_inf = (a.exp == 5'h1F) && (a.frac == '0);
  assign b_inf = (b.exp == 5'h1F) && (b.frac == '0);

  always_comb begin
    result_d   = {big.sign, mag[14:0]};
    overflow_d = 1'b0;
    zero_d     = 1'b0;
    nan_d      = 1'b0;
    lost_d     = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf && !same_sign)) begin
      result_d = QNAN;
      nan_d    = 1'b1;
    end else if (a_inf) begin
      result_d = num1;
    end else if (b_inf) begin
      result_d = num2;
    end else if (sum == '0) begin
      // Only -0 + -0 keeps a negative sign; exact cancellation gives +0.
      result_d = {a.sign & same_sign, 15'b0};
      zero_d   = 1'b1;
    end else if (fin_ovf) begin
      result_d   = big.sign ? NEG_INF : POS_INF;
      overflow_d = 1'b1;
      lost_d     = grs;
    end else begin
      lost_d = grs;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= 16'h0000;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
      nan_q      <= 1'b0;
      lost_q     <= 1'b0;
    end else begin
      result_q   <= result_d;
      overflow_q <= overflow_d;
      zero_q     <= zero_d;
      nan_q      <= nan_d;
      lost_q     <= lost_d;
    end
  end

  assign result        = result_q;
  assign overflow      = overflow_q;
  assign zero          = zero_q;
  assign nan           = nan_q;
  assign precisionLost = lost_q;
endmodule

// File: tb/tb_fp16_adder.sv
// Self-checking bench for fp16_adder: directed vectors plus randomized operands
// checked against an exact integer reference model (units of 2^-24).
module tb_fp16_adder;
  logic        clk;
  logic        rst;
  logic [15:0] num1, num2;
  logic [15:0] result;
  logic        overflow, zero, nan, precisionLost;

  int total = 0;
  int bad   = 0;
  logic [19:0] exp_q[$];

  fp16_adder dut (
    .clk           (clk),
    .rst           (rst),
    .num1          (num1),
    .num2          (num2),
    .result        (result),
    .overflow      (overflow),
    .zero          (zero),
    .nan           (nan),
    .precisionLost (precisionLost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic longint to_units(input logic [15:0] x);
    longint mag;
    int     e;
    e = int'(x[14:10]);
    if (e == 0) mag = longint'(x[9:0]);
    else        mag = longint'({1'b1, x[9:0]}) <<< (e - 1);
    return x[15] ? -mag : mag;
  endfunction

  // Returns {result, overflow, zero, nan, precisionLost}.
  function automatic logic [19:0] ref_add(input logic [15:0] x, input logic [15:0] y);
    logic   x_nan, y_nan, x_inf, y_inf, neg, inexact;
    longint s, m, q, rem, half;
    int     k, e;
    x_nan = (x[14:10] == 5'h1F) && (x[9:0] != 0);
    y_nan = (y[14:10] == 5'h1F) && (y[9:0] != 0);
    x_inf = (x[14:10] == 5'h1F) && (x[9:0] == 0);
    y_inf = (y[14:10] == 5'h1F) && (y[9:0] == 0);
    if (x_nan || y_nan || (x_inf && y_inf && (x[15] != y[15])))
      return {16'h7E00, 4'b0010};
    if (x_inf) return {x, 4'b0000};
    if (y_inf) return {y, 4'b0000};
    s = to_units(x) + to_units(y);
    if (s == 0) return {x[15] & y[15], 15'b0, 4'b0100};
    neg = (s < 0);
    m   = neg ? -s : s;
    k   = 0;
    for (int i = 0; i < 42; i++) if (m[i]) k = i;
    if (k < 10) return {neg, 5'd0, 10'(m), 4'b0000};
    q       = m >> (k - 10);
    rem     = m - (q << (k - 10));
    inexact = (rem != 0);
`ifdef FP16_ADD_RNE_EN
    if (k > 10) begin
      half = longint'(1) << (k - 11);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == 2048) begin
        q = 1024;
        k = k + 1;
      end
    end
`else
    half = 0;
`endif
    e = k - 9;
    if (e >= 31) return {(neg ? 16'hFC00 : 16'h7C00), 3'b100, inexact};
    return {neg, 5'(e), 10'(q), 3'b000, inexact};
  endfunction

  function automatic logic [15:0] rand_op();
    logic s;
    s = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      0:       return 16'($urandom);
      1:       return {s, 5'd0, 10'($urandom)};
      2:       return {s, 5'($urandom_range(13, 17)), 10'($urandom)};
      3:       return {s, 5'($urandom_range(28, 30)), 10'($urandom)};
      4:       return {s, 5'h1F, 10'($urandom_range(0, 1))};
      5:       return {s, 15'd0};
      default: return {s, 5'($urandom_range(0, 30)), 10'($urandom)};
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic apply(input logic [15:0] x, input logic [15:0] y);
    @(negedge clk);
    num1 = x;
    num2 = y;
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      apply(16'h3C00, 16'h4000 + 16'(i));
      total++;
      if ({result, overflow, zero, nan, precisionLost} !== 20'h0) begin
        bad++;
        $display("FAIL reset[%0d] got=%h req=%h", i,
                 {result, overflow, zero, nan, precisionLost}, 20'h0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [15:0] va[14] = '{16'hB9A8, 16'hC03E, 16'hC200, 16'hBC00, 16'h00B8, 16'hB200, 16'h7BFF,
                           16'h7C01, 16'h7C00, 16'h5400, 16'h8000, 16'h0000, 16'h7C00, 16'hFC00};
    logic [15:0] vb[14] = '{16'hC03E, 16'h39A8, 16'hC1A8, 16'hBDA8, 16'h0080, 16'h3200, 16'h7BFF,
                           16'h3C00, 16'hFC00, 16'h0001, 16'h8000, 16'h8000, 16'h3C00, 16'hFC00};
    logic [19:0] ve[14] = '{{16'hC1A8, 4'b0000}, {16'hBDA8, 4'b0000}, {16'hC5D4, 4'b0000},
                           {16'hC0D4, 4'b0000}, {16'h0138, 4'b0000}, {16'h0000, 4'b0100},
                           {16'h7C00, 4'b1000}, {16'h7E00, 4'b0010}, {16'h7E00, 4'b0010},
                           {16'h5400, 4'b0001}, {16'h8000, 4'b0100}, {16'h0000, 4'b0100},
                           {16'h7C00, 4'b0000}, {16'hFC00, 4'b0000}};
    for (int i = 0; i < 14; i++) begin
      apply(va[i], vb[i]);
      total++;
      if ({result, overflow, zero, nan, precisionLost} !== ve[i]) begin
        bad++;
        $display("FAIL directed[%0d] a=%h b=%h got=%h req=%h", i, va[i], vb[i],
                 {result, overflow, zero, nan, precisionLost}, ve[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] x, y;
    logic [19:0] e;
    for (int i = 0; i < 400; i++) begin
      x = rand_op();
      y = rand_op();
      case ($urandom_range(0, 9))
        0:       y = x ^ 16'h8000;
        1:       y = (x ^ 16'h8000) + 16'($urandom_range(0, 3));
        default: ;
      endcase
      e = ref_add(x, y);
      apply(x, y);
      total++;
      if ({result, overflow, zero, nan, precisionLost} !== e) begin
        bad++;
        $display("FAIL random[%0d] a=%h b=%h got=%h req=%h", i, x, y,
                 {result, overflow, zero, nan, precisionLost}, e);
      end
    end
  endtask

  task automatic test_latency();
    logic [19:0] e;
    e = ref_add(16'h3C00, 16'h3C00);
    apply(16'h3C00, 16'h3C00);
    // New operands must not reach the outputs before the next edge.
    @(negedge clk);
    num1 = 16'hC200;
    num2 = 16'hC1A8;
    #1;
    total++;
    if ({result, overflow, zero, nan, precisionLost} !== e) begin
      bad++;
      $display("FAIL latency_hold got=%h req=%h", {result, overflow, zero, nan, precisionLost}, e);
    end
    @(posedge clk);
    #1;
    total++;
    if ({result, overflow, zero, nan, precisionLost} !== {16'hC5D4, 4'b0000}) begin
      bad++;
      $display("FAIL latency_next got=%h req=%h", {result, overflow, zero, nan, precisionLost},
               {16'hC5D4, 4'b0000});
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] x, y;
    logic [19:0] e;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      x = rand_op();
      y = (i % 5 == 0) ? (x ^ 16'h8000) : rand_op();
      num1 = x;
      num2 = y;
      exp_q.push_back(ref_add(x, y));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      total++;
      if ({result, overflow, zero, nan, precisionLost} !== e) begin
        bad++;
        $display("FAIL b2b[%0d] a=%h b=%h got=%h req=%h", i, x, y,
                 {result, overflow, zero, nan, precisionLost}, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [19:0] e;
    apply(16'h7BFF, 16'h7BFF);
    @(negedge clk);
    rst  = 1'b1;
    num1 = 16'h7C01;
    num2 = 16'h5400;
    @(posedge clk);
    #1;
    total++;
    if ({result, overflow, zero, nan, precisionLost} !== 20'h0) begin
      bad++;
      $display("FAIL mid_reset got=%h req=%h", {result, overflow, zero, nan, precisionLost}, 20'h0);
    end
    @(negedge clk);
    rst = 1'b0;
    e = ref_add(16'h5400, 16'h0001);
    apply(16'h5400, 16'h0001);
    total++;
    if ({result, overflow, zero, nan, precisionLost} !== e) begin
      bad++;
      $display("FAIL after_reset got=%h req=%h", {result, overflow, zero, nan, precisionLost}, e);
    end
  endtask

  initial begin
    rst  = 1'b1;
    num1 = 16'h0000;
    num2 = 16'h0000;
    test_reset();
    test_directed();
    test_latency();
    test_random();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
